// File: rtl/blinker_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : blinker_multi
// Brief    : Multi-channel LED driver (OFF/ON/BLINK/PWM) with a shared
//            prescaler tick and a valid/ready per-channel config port.
// Revision : 1.0
// ============================================================================
module blinker_multi #(
    parameter int NUM_CHANNELS = 4,
    parameter int PRESCALE     = 50000,
    parameter int PERIOD_WIDTH = 16,
    parameter int DUTY_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [3:0]              cfg_chan,
    input  logic [1:0]              cfg_mode,
    input  logic [PERIOD_WIDTH-1:0] cfg_period,
    input  logic [DUTY_WIDTH-1:0]   cfg_duty,
    output logic                    cfg_err,
    output logic                    tick,
    output logic [NUM_CHANNELS-1:0] out
);

    localparam int                  c_pre_w   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pre_w-1:0]  c_pre_max = c_pre_w'(PRESCALE - 1);
    localparam logic [4:0]          c_num_ch  = 5'(NUM_CHANNELS);

    localparam logic [1:0] c_mode_off   = 2'd0;
    localparam logic [1:0] c_mode_on    = 2'd1;
    localparam logic [1:0] c_mode_blink = 2'd2;

    logic [c_pre_w-1:0] r_pre_cnt;
    logic               r_tick;
    logic               r_ready;
    logic               r_err;
    logic               w_accept;

    assign w_accept  = cfg_valid && r_ready;
    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;
    assign tick      = r_tick;

    // Prescaler and handshake; ready drops for one cycle after every accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
            r_tick    <= 1'b0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_pre_cnt <= (r_pre_cnt == c_pre_max) ? '0 : r_pre_cnt + 1'b1;
            r_tick    <= (r_pre_cnt == c_pre_max);
            r_ready   <= !w_accept;
            r_err     <= w_accept && ({1'b0, cfg_chan} >= c_num_ch);
        end
    end

    generate
        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
            logic [1:0]              r_mode;
            logic [PERIOD_WIDTH-1:0] r_period;
            logic [PERIOD_WIDTH-1:0] r_cnt;
            logic [DUTY_WIDTH-1:0]   r_duty;
            logic [DUTY_WIDTH-1:0]   r_phase;
            logic [DUTY_WIDTH-1:0]   w_phase_nxt;
            logic                    r_led;
            logic                    w_load;

            assign w_load      = w_accept && (cfg_chan == 4'(c));
            assign w_phase_nxt = r_phase + 1'b1;
            assign out[c]      = r_led;

            // A load takes priority over a coincident tick for this channel only.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_mode   <= c_mode_off;
                    r_period <= '0;
                    r_cnt    <= '0;
                    r_duty   <= '0;
                    r_phase  <= '0;
                    r_led    <= 1'b0;
                end else if (w_load) begin
                    r_mode   <= cfg_mode;
                    r_period <= cfg_period;
                    r_duty   <= cfg_duty;
                    r_cnt    <= '0;
                    r_phase  <= '0;
                    case (cfg_mode)
                        c_mode_off:   r_led <= 1'b0;
                        c_mode_on:    r_led <= 1'b1;
                        c_mode_blink: r_led <= 1'b1;
                        default:      r_led <= (cfg_duty != '0);
                    endcase
                end else begin
                    case (r_mode)
                        c_mode_off: r_led <= 1'b0;
                        c_mode_on:  r_led <= 1'b1;
                        c_mode_blink: begin
                            if (r_tick) begin
                                if (r_cnt == r_period) begin
                                    r_cnt <= '0;
                                    r_led <= ~r_led;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end
                        end
                        default: begin
                            // Output registered from the next phase so it tracks phase < duty.
                            if (r_tick) begin
                                r_phase <= w_phase_nxt;
                                r_led   <= (w_phase_nxt < r_duty);
                            end
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_blinker_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_blinker_multi
// Brief    : Randomized bench for blinker_multi against a ticks-since-config model.
// Revision : 1.0
// ============================================================================
module tb_blinker_multi;

    localparam int NCH = 4;
    localparam int PRE = 4;
    localparam int PW  = 8;
    localparam int DW  = 4;

    logic           clk;
    logic           rst_n;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [3:0]     cfg_chan;
    logic [1:0]     cfg_mode;
    logic [PW-1:0]  cfg_period;
    logic [DW-1:0]  cfg_duty;
    logic           cfg_err;
    logic           tick;
    logic [NCH-1:0] out;

    blinker_multi #(
        .NUM_CHANNELS (NCH),
        .PRESCALE     (PRE),
        .PERIOD_WIDTH (PW),
        .DUTY_WIDTH   (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_err    (cfg_err),
        .tick       (tick),
        .out        (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each channel is described by its config plus the number of
    // ticks it has seen since that config was written.
    bit m_ready, m_err, m_tick;
    int m_n;
    int m_mode[NCH], m_period[NCH], m_duty[NCH], m_t[NCH];

    function automatic logic exp_led(input int c);
        case (m_mode[c])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((m_t[c] / (m_period[c] + 1)) % 2) == 0;
            default: return (m_t[c] % (1 << DW)) < m_duty[c];
        endcase
    endfunction

    task automatic model_edge();
        bit acc, tick_in;
        if (!rst_n) begin
            m_ready = 0; m_err = 0; m_tick = 0; m_n = 0;
            for (int c = 0; c < NCH; c++) begin
                m_mode[c] = 0; m_period[c] = 0; m_duty[c] = 0; m_t[c] = 0;
            end
        end else begin
            tick_in = m_tick;
            acc     = cfg_valid && m_ready;
            for (int c = 0; c < NCH; c++) begin
                if (acc && int'(cfg_chan) == c) begin
                    m_mode[c]   = int'(cfg_mode);
                    m_period[c] = int'(cfg_period);
                    m_duty[c]   = int'(cfg_duty);
                    m_t[c]      = 0;
                end else if (tick_in && m_mode[c] >= 2) begin
                    m_t[c]++;
                end
            end
            m_err   = acc && (int'(cfg_chan) >= NCH);
            m_ready = !acc;
            m_n++;
            m_tick  = (m_n % PRE) == 0;
        end
    endtask

    task automatic step();
        logic [NCH-1:0] exp_out;
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < NCH; c++) exp_out[c] = exp_led(c);
        check_eq("cfg_ready", 32'(cfg_ready), 32'(m_ready));
        check_eq("tick",      32'(tick),      32'(m_tick));
        check_eq("cfg_err",   32'(cfg_err),   32'(m_err));
        check_eq("out",       32'(out),       32'(exp_out));
    endtask

    task automatic drive_write(input int ch, input int md, input int per, input int dty);
        cfg_valid  = 1'b1;
        cfg_chan   = 4'(ch);
        cfg_mode   = 2'(md);
        cfg_period = PW'(per);
        cfg_duty   = DW'(dty);
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_mode = '0;
        cfg_period = '0; cfg_duty = '0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) step();

        // Back-to-back requests: only every other one is accepted.
        for (int i = 0; i < 6; i++) begin
            drive_write(i % NCH, 2, 1, 0);
            step();
        end
        cfg_valid = 1'b0;
        repeat (4) step();

        // Nonexistent channel.
        drive_write(7, 1, 0, 0);
        step();
        cfg_valid = 1'b0;
        repeat (3) step();

        // Directed waveforms: BLINK period 2 on ch0, PWM duty 4 / 15 / 0.
        drive_write(0, 2, 2, 0); step(); cfg_valid = 1'b0; step();
        drive_write(1, 3, 0, 4); step(); cfg_valid = 1'b0; step();
        drive_write(3, 3, 0, 15); step(); cfg_valid = 1'b0; step();
        drive_write(2, 3, 0, 0); step(); cfg_valid = 1'b0;
        repeat (140) step();

        // Write ch2 on an edge that carries a tick.
        for (int k = 0; k < 2 * PRE && !m_tick; k++) step();
        check_eq("tick_seen", 32'(m_tick), 32'd1);
        drive_write(2, 2, 1, 0); step(); cfg_valid = 1'b0;
        repeat (30) step();

        // Mid-run reset.
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        repeat (8) step();

        for (int k = 0; k < 4000; k++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 29) == 0) begin
                int d;
                case ($urandom_range(0, 3))
                    0:       d = 0;
                    1:       d = (1 << DW) - 1;
                    default: d = int'($urandom_range(0, (1 << DW) - 1));
                endcase
                drive_write(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                            int'($urandom_range(0, 3)), d);
            end else begin
                cfg_valid = 1'b0;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/blinker_multi.md
Name: blinker_multi

Overview:
- Parametrised multi-channel successor to the single-output LED blinker.
- Drives NUM_CHANNELS independent outputs. Each output runs in one of four runtime-selectable modes: OFF, ON, BLINK, PWM.
- All channels share one global prescaler tick.
- Software/top-level logic programs each channel through a valid/ready config port. The block sits between board-level control logic and the LED pins.

Parameters:
- NUM_CHANNELS, 4, number of independent outputs (1..16).
- PRESCALE, 50000, clock cycles per tick (>=1).
- PERIOD_WIDTH, 16, width of per-channel BLINK period register.
- DUTY_WIDTH, 8, width of PWM duty/phase; one PWM frame = 2^DUTY_WIDTH ticks.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  block can accept a config write.
- cfg_chan  in  4  target channel index.
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=PWM.
- cfg_period  in  PERIOD_WIDTH  BLINK half-period minus one, in ticks.
- cfg_duty  in  DUTY_WIDTH  PWM high ticks per frame.
- cfg_err  out  1  one-cycle pulse: accepted write targeted a nonexistent channel.
- tick  out  1  one-cycle prescaler pulse, exported for debug/sync.
- out  out  NUM_CHANNELS  LED drive, registered.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset values (rst_n=0 at an edge): out=0, tick=0, cfg_ready=0, cfg_err=0. All modes=OFF; period, duty, per-channel counters and prescaler counter = 0.
  - cfg_ready rises on the first edge with rst_n=1.
  - Reset asserted mid-operation returns everything to these values at that edge; in-flight config is discarded.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - tick=1 for exactly the cycle after pre_cnt==PRESCALE-1. PRESCALE=1 gives tick=1 every cycle after reset.
  - Config writes never reset the prescaler.
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready at an edge.
  - cfg_ready goes 0 for exactly the following cycle, then returns to 1. Maximum write rate is 1 per 2 cycles.
  - Inputs only need to be stable at the accepting edge.
- Accepted write, cfg_chan < NUM_CHANNELS, applied at the accepting edge:
  - mode, period and duty are loaded; the channel's counter and phase are cleared to 0.
  - out[c] next cycle: OFF=0, ON=1, BLINK=1, PWM=(cfg_duty!=0).
  - A tick coinciding with the accepting edge is ignored by that channel only; other channels process it normally.
- Accepted write, cfg_chan >= NUM_CHANNELS: no state change except cfg_err=1 for exactly the next cycle.
- OFF: out[c]=0 constant. ON: out[c]=1 constant. Counters are held.
- BLINK, on each tick:
  - if cnt==period: cnt<=0 and out[c] toggles; else cnt<=cnt+1.
  - Each level lasts period+1 ticks. period=0 toggles every tick.
  - Counter width is PERIOD_WIDTH; no overflow is possible since cnt<=period.
- PWM:
  - phase (DUTY_WIDTH bits) increments on each tick and wraps 2^DUTY_WIDTH-1 -> 0.
  - out[c] == (phase < duty) in every cycle. Implemented as a register; no combinational path from state to out.
  - duty=0: always 0. duty=2^DUTY_WIDTH-1: low exactly 1 tick per frame. Comparison is unsigned.
- Channels are fully independent; simultaneous tick on all channels is the normal case.
- Reconfiguring a channel with its current mode still restarts its counter and phase.

Test Plan:
- Reset with PRESCALE=4: hold rst_n=0 3 cycles, release -> out=0, cfg_ready=0 during reset and 1 on the first edge after release; tick pulses every 4 cycles, width 1.
- BLINK: NUM_CHANNELS=4, PRESCALE=4; write ch0 mode=2 period=2 -> out[0]=1 next cycle; after first toggle, every level lasts exactly 12 cycles; out[3:1] stay 0.
- PWM: DUTY_WIDTH=4; write ch1 mode=3 duty=4 -> out[1] high 4 ticks (16 cycles), low 12 ticks (48 cycles) per 64-cycle frame. duty=0 gives constant 0; duty=15 gives exactly 1 low tick per frame.
- Handshake: hold cfg_valid=1 for 6 cycles with a different channel each cycle -> exactly 3 writes accepted, cfg_ready toggles 1,0,1,0,1,0.
- Error: write cfg_chan=7 with NUM_CHANNELS=4 -> cfg_err=1 for 1 cycle; out and all channel state unchanged.
- Collision and mid-run reset: write ch2 BLINK on a tick edge -> ch2 counter=0 and ignores that tick while ch0 still advances. Then assert rst_n=0 mid-frame -> all outputs 0 at the next edge, modes OFF.
